// File: rtl/mem_access_stage_pkg.sv
// Shared opcode constants, FSM state type and defaults for the memory-access stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_access_stage_pkg;

  // ALU opcodes that produce a register result
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_EOR = 4'b0100;
  localparam logic [3:0] OP_LSL = 4'b0101;
  localparam logic [3:0] OP_LSR = 4'b0110;
  localparam logic [3:0] OP_MOV = 4'b0111;
  // Flag-only compare and the two memory opcodes
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  // Default cycles a request may stay unacknowledged before it is aborted
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Memory is word addressed: drop the byte offset
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_stage_timeout_counter.sv
// Counts unacknowledged request cycles and flags the cycle in which the limit is hit.
// Latency: tc is combinational from the count register and en.
// Backpressure: none; clr wins over en.
module mem_timeout_counter
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // tc fires in the cycle whose increment would bring the count to TIMEOUT
  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear while idle, advance on each waiting cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// Registers ALU results for writeback and runs load/store req/ack with data memory.
// Latency: ALU op 1 cycle; load/store 1 cycle to Mem_req, writeback the cycle after ack.
// Backpressure: Ex_ready low while a memory request is outstanding. Optional abort: MEM_TIMEOUT_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Ex_valid,
  output logic        Ex_ready,
  input  logic [3:0]  Opcode,
  input  logic        Condition_met,
  input  logic [31:0] Alu_out,
  input  logic [31:0] Store_data,
  input  logic [3:0]  Rd,
  output logic        Mem_req,
  output logic        Mem_we,
  output logic [31:0] Mem_addr,
  output logic [31:0] Mem_wdata,
  input  logic        Mem_ack,
  input  logic [31:0] Mem_rdata,
  output logic        Wb_valid,
  output logic [3:0]  Wb_rd,
  output logic [31:0] Wb_data,
  output logic        Mem_err
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_access_stage: TIMEOUT must be within 2..255");
  end

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  rd_q, rd_d;
  logic        wb_vld_q, wb_vld_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_dat_q, wb_dat_d;

`ifdef MEM_TIMEOUT_EN
  logic err_q, err_d;
  logic tmo_tc;

  // Counter is held clear while idle, so it starts from zero on every request
  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_IDLE),
    .en  ((state_q == ST_REQ) && !Mem_ack),
    .tc  (tmo_tc)
  );
`endif

  // Decode accepted instructions and sequence the memory handshake
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wb_vld_d = 1'b0;
    wb_rd_d  = wb_rd_q;
    wb_dat_d = wb_dat_q;
`ifdef MEM_TIMEOUT_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Ex_ready is high in IDLE, so Ex_valid alone means accepted
        if (Ex_valid && Condition_met) begin
          case (Opcode)
            OP_ADD, OP_SUB, OP_AND, OP_ORR,
            OP_EOR, OP_LSL, OP_LSR, OP_MOV: begin
              wb_vld_d = 1'b1;
              wb_rd_d  = Rd;
              wb_dat_d = Alu_out;
            end
            OP_LDR, OP_STR: begin
              addr_d  = word_addr(Alu_out);
              we_d    = (Opcode == OP_STR);
              wdata_d = Store_data;
              rd_d    = Rd;
              state_d = ST_REQ;
            end
            OP_CMP: begin
              // Flags only; nothing to write back
            end
            default: begin
            end
          endcase
        end
      end
      ST_REQ: begin
        // Ack takes priority over a timeout in the same cycle
        if (Mem_ack) begin
          state_d = ST_IDLE;
          if (!we_q) begin
            wb_vld_d = 1'b1;
            wb_rd_d  = rd_q;
            wb_dat_d = Mem_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_tc) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding request at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rd_q     <= '0;
      wb_vld_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wb_vld_q <= wb_vld_d;
      wb_rd_q  <= wb_rd_d;
      wb_dat_q <= wb_dat_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // One-cycle abort pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign Mem_err = err_q;
`else
  assign Mem_err = 1'b0;
`endif

  assign Ex_ready  = (state_q == ST_IDLE);
  assign Mem_req   = (state_q == ST_REQ);
  assign Mem_we    = we_q;
  assign Mem_addr  = addr_q;
  assign Mem_wdata = wdata_q;
  assign Wb_valid  = wb_vld_q;
  assign Wb_rd     = wb_rd_q;
  assign Wb_data   = wb_dat_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed cases then randomized instruction stream.
// Expected writebacks/requests are queued at issue; a responder and a monitor check them.
// Memory responder applies configurable or random ack latency.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Ex_valid = 1'b0;
  logic        Ex_ready;
  logic [3:0]  Opcode = '0;
  logic        Condition_met = 1'b0;
  logic [31:0] Alu_out = '0;
  logic [31:0] Store_data = '0;
  logic [3:0]  Rd = '0;
  logic        Mem_req;
  logic        Mem_we;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_wdata;
  logic        Mem_ack = 1'b0;
  logic [31:0] Mem_rdata = '0;
  logic        Wb_valid;
  logic [3:0]  Wb_rd;
  logic [31:0] Wb_data;
  logic        Mem_err;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .Ex_valid(Ex_valid), .Ex_ready(Ex_ready),
    .Opcode(Opcode), .Condition_met(Condition_met), .Alu_out(Alu_out),
    .Store_data(Store_data), .Rd(Rd), .Mem_req(Mem_req), .Mem_we(Mem_we),
    .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata), .Mem_ack(Mem_ack),
    .Mem_rdata(Mem_rdata), .Wb_valid(Wb_valid), .Wb_rd(Wb_rd),
    .Wb_data(Wb_data), .Mem_err(Mem_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] rd; logic [31:0] data; int due; } wb_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;

  wb_t  sb[$];
  req_t rq[$];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] resp_mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ack_cyc = -100;
  int wb_seen = 0;
  int err_cnt = 0;
  int req_cyc = 0;
  int ack_lat = 0;
  bit ack_rand = 1'b0;
  bit stray_ack = 1'b0;
  req_t cur_req;
  req_t exp_r;
  wb_t  exp_w;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: checks each new request against the expected queue, acks after ack_lat cycles
  always @(negedge clk) begin
    Mem_ack = 1'b0;
    if (rst) begin
      req_cyc = 0;
    end else if (Mem_req === 1'b1) begin
      req_cyc++;
      if (req_cyc == 1) begin
        cur_req.we = Mem_we; cur_req.addr = Mem_addr; cur_req.wdata = Mem_wdata;
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr 0x%08h we %0d, expected no request", Mem_addr, Mem_we);
        end else begin
          exp_r = rq.pop_front();
          chk("req_we", 32'(Mem_we), 32'(exp_r.we));
          chk("req_addr", Mem_addr, exp_r.addr);
          if (exp_r.we) chk("req_wdata", Mem_wdata, exp_r.wdata);
        end
        if (ack_rand) ack_lat = $urandom_range(1, 3);
      end else begin
        chk("req_addr_stable", Mem_addr, cur_req.addr);
        chk("req_we_stable", 32'(Mem_we), 32'(cur_req.we));
        chk("req_wdata_stable", Mem_wdata, cur_req.wdata);
      end
      if (ack_lat != 0 && req_cyc == ack_lat) begin
        Mem_ack = 1'b1;
        if (Mem_we) begin
          resp_mem[Mem_addr] = Mem_wdata;
          Mem_rdata = $urandom;
        end else begin
          Mem_rdata = resp_mem.exists(Mem_addr) ? resp_mem[Mem_addr] : init_word(Mem_addr);
        end
        last_ack_cyc = cyc;
      end
    end else begin
      req_cyc = 0;
      if (stray_ack) begin
        Mem_ack = 1'b1;
        Mem_rdata = $urandom;
        stray_ack = 1'b0;
      end
    end
  end

  // Writeback monitor: every strobe must match the head of the scoreboard, in the right cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (Mem_err === 1'b1) err_cnt++;
      if (Wb_valid === 1'b1) begin
        wb_seen++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: rd %0d data 0x%08h, expected no writeback", Wb_rd, Wb_data);
        end else begin
          exp_w = sb.pop_front();
          chk("wb_rd", 32'(Wb_rd), 32'(exp_w.rd));
          chk("wb_data", Wb_data, exp_w.data);
          chk("wb_cycle", 32'(cyc), 32'((exp_w.due >= 0) ? exp_w.due : last_ack_cyc + 1));
        end
      end
    end
  end

  // Reference model: what an accepted instruction must eventually produce
  task automatic model_accept(input logic [3:0] op, input logic cond, input logic [31:0] alu,
                              input logic [31:0] sd, input logic [3:0] rd);
    wb_t w;
    req_t r;
    logic [31:0] a;
    if (!cond) return;
    a = {alu[31:2], 2'b00};
    if (op <= 4'd7) begin
      w.rd = rd; w.data = alu; w.due = cyc + 1;
      sb.push_back(w);
    end else if (op == 4'hD) begin
      r.we = 1'b0; r.addr = a; r.wdata = sd;
      rq.push_back(r);
      w.rd = rd; w.data = ref_mem.exists(a) ? ref_mem[a] : init_word(a); w.due = -1;
      sb.push_back(w);
    end else if (op == 4'hE) begin
      r.we = 1'b1; r.addr = a; r.wdata = sd;
      rq.push_back(r);
      ref_mem[a] = sd;
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance with Ex_valid low
  task automatic issue(input logic [3:0] op, input logic cond, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [3:0] rd);
    int guard;
    guard = 0;
    Ex_valid = 1'b1; Opcode = op; Condition_met = cond; Alu_out = alu; Store_data = sd; Rd = rd;
    while (Ex_ready !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 40) begin
        checks++; errors++;
        $display("FAIL issue_timeout: Ex_ready stayed 0 for %0d cycles, expected 1", guard);
        Ex_valid = 1'b0;
        return;
      end
    end
    model_accept(op, cond, alu, sd, rd);
    @(negedge clk);
    Ex_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wbs;
    int e0;
    int n;
    int exp_err;
    logic [3:0] op;
    logic [31:0] alu;

    repeat (2) @(negedge clk);
    chk("rst_ex_ready", 32'(Ex_ready), 32'd1);
    chk("rst_mem_req", 32'(Mem_req), 32'd0);
    chk("rst_mem_we", 32'(Mem_we), 32'd0);
    chk("rst_mem_addr", Mem_addr, 32'd0);
    chk("rst_mem_wdata", Mem_wdata, 32'd0);
    chk("rst_wb_valid", 32'(Wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(Wb_rd), 32'd0);
    chk("rst_wb_data", Wb_data, 32'd0);
    chk("rst_mem_err", 32'(Mem_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ALU results, back to back
    issue(4'h0, 1'b1, 32'h0000_0007, 32'h0, 4'd3);
    issue(4'h1, 1'b1, 32'h1234_5678, 32'h0, 4'hA);
    issue(4'h7, 1'b1, 32'hFFFF_0001, 32'h0, 4'hF);
    idle(2);

    // Load with ack in the third request cycle
    ref_mem[32'h1004] = 32'hDEAD_BEEF;
    resp_mem[32'h1004] = 32'hDEAD_BEEF;
    ack_lat = 3;
    issue(4'hD, 1'b1, 32'h0000_1006, 32'h0, 4'd5);
    chk("load_stall_1", 32'(Ex_ready), 32'd0);
    @(negedge clk);
    chk("load_stall_2", 32'(Ex_ready), 32'd0);
    @(negedge clk);
    chk("load_stall_3", 32'(Ex_ready), 32'd0);
    @(negedge clk);
    chk("load_ready_after_ack", 32'(Ex_ready), 32'd1);
    chk("load_wb_valid", 32'(Wb_valid), 32'd1);
    chk("load_wb_data", Wb_data, 32'hDEAD_BEEF);
    chk("load_mem_req_dropped", 32'(Mem_req), 32'd0);
    idle(1);

    // Store: no writeback
    ack_lat = 2;
    wbs = wb_seen;
    issue(4'hE, 1'b1, 32'h0000_0020, 32'h0000_0055, 4'd2);
    idle(4);
    chk("store_no_wb", 32'(wb_seen), 32'(wbs));

    // Squashed load and compare: neither touches memory nor writes back
    wbs = wb_seen;
    issue(4'hD, 1'b0, 32'h0000_0040, 32'h0, 4'd1);
    chk("squash_no_req", 32'(Mem_req), 32'd0);
    issue(4'hB, 1'b1, 32'h0000_0009, 32'h0, 4'd6);
    idle(3);
    chk("squash_cmp_no_wb", 32'(wb_seen), 32'(wbs));

    // Reset while a request is outstanding
    ack_lat = 0;
    issue(4'hD, 1'b1, 32'h0000_0080, 32'h0, 4'd7);
    idle(1);
    chk("pre_reset_req", 32'(Mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("reset_req_drop", 32'(Mem_req), 32'd0);
    chk("reset_ex_ready", 32'(Ex_ready), 32'd1);
    chk("reset_wb_valid", 32'(Wb_valid), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    stray_ack = 1'b1;
    wbs = wb_seen;
    idle(4);
    chk("post_reset_no_wb", 32'(wb_seen), 32'(wbs));
    chk("post_reset_idle", 32'(Ex_ready), 32'd1);

`ifdef MEM_TIMEOUT_EN
    // No ack: request held for TIMEOUT cycles then aborted with one error pulse
    ack_lat = 0;
    e0 = err_cnt;
    wbs = wb_seen;
    issue(4'hD, 1'b1, 32'h0000_00C0, 32'h0, 4'd8);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (Mem_req === 1'b1) n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeout_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("timeout_ex_ready", 32'(Ex_ready), 32'd1);
    chk("timeout_no_wb", 32'(wb_seen), 32'(wbs));
    sb.delete();

    // Ack in the limit cycle completes normally
    ack_lat = 4;
    e0 = err_cnt;
    wbs = wb_seen;
    issue(4'hD, 1'b1, 32'h0000_00C4, 32'h0, 4'd9);
    idle(7);
    chk("ack_at_limit_no_err", 32'(err_cnt - e0), 32'd0);
    chk("ack_at_limit_wb", 32'(wb_seen - wbs), 32'd1);
`endif

    // Randomized instruction stream with random memory latency
    ack_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hD || op == 4'hE) alu = 32'($urandom_range(0, 255));
        else alu = $urandom;
        issue(op, ($urandom_range(0, 4) != 0), alu, $urandom, 4'($urandom_range(0, 15)));
      end
    end
    idle(10);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("requests_drained", 32'(rq.size()), 32'd0);
`ifdef MEM_TIMEOUT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    chk("mem_err_total", 32'(err_cnt), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline stage directly downstream of the combinational ALU. It registers the ALU result and, for load (opcode 4'b1101) and store (4'b1110), runs a request/acknowledge transaction with data memory. It stalls the execute stage while a transaction is outstanding and hands one result per instruction to register writeback.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles `Mem_req` is held without `Mem_ack` before abort. Valid range 2..255. Used only when `MEM_TIMEOUT_EN` is defined.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- Ex_valid  input  1  execute stage presents an instruction
- Ex_ready  output  1  stage accepts; an instruction is taken when Ex_valid && Ex_ready
- Opcode  input  4  ALU opcode of the instruction
- Condition_met  input  1  ALU condition result; 0 squashes the instruction
- Alu_out  input  32  ALU Out: result, or byte address for load/store
- Store_data  input  32  register value to store
- Rd  input  4  destination register
- Mem_req  output  1  memory request, held until ack or abort
- Mem_we  output  1  1 = write (store), 0 = read (load)
- Mem_addr  output  32  word-aligned address, {Alu_out[31:2], 2'b00}
- Mem_wdata  output  32  store data
- Mem_ack  input  1  memory completes the request this cycle
- Mem_rdata  input  32  read data, valid when Mem_ack is high
- Wb_valid  output  1  one-cycle writeback strobe
- Wb_rd  output  4  writeback destination
- Wb_data  output  32  writeback value
- Mem_err  output  1  one-cycle timeout-abort pulse; tied 0 when the macro is absent

## Operation
- FSM states:
  - IDLE: Ex_ready=1.
  - REQ: Ex_ready=0, Mem_req=1.
- IDLE, accepted instruction with Condition_met=0: no memory access, no writeback.
- IDLE, accepted ALU op (0000–0101, 0110, 0111): the next cycle has Wb_valid=1, Wb_data=Alu_out, Wb_rd=Rd. State stays IDLE.
- IDLE, accepted compare (1011) or any other opcode not listed: no writeback.
- IDLE, accepted load or store: Mem_addr, Mem_we and Mem_wdata are registered, then IDLE→REQ.
- REQ with Mem_ack=1: Mem_req drops the next cycle and the FSM returns to IDLE.
  - Load: Wb_valid=1, Wb_data=Mem_rdata, Wb_rd=captured Rd in that same next cycle.
  - Store: no writeback.
- Mem_addr, Mem_we and Mem_wdata stay stable for the whole time Mem_req is high.
- Mem_ack outside REQ is ignored.
- Reset:
  - Outputs: Ex_ready=1, Mem_req=0, Mem_we=0, Mem_addr=0, Mem_wdata=0, Wb_valid=0, Wb_rd=0, Wb_data=0, Mem_err=0. State=IDLE.
  - Reset during REQ abandons the transaction immediately (asynchronously) and produces no writeback.

## Timing
- ALU op: accept at edge N, Wb_valid high in cycle N+1. Throughput is 1 per cycle.
- Load/store: accept at edge N, Mem_req high from cycle N+1. Ack sampled at edge M drops Mem_req and gives Ex_ready=1 in cycle M+1; a load's Wb_valid is also in cycle M+1.
- Best-case load (ack in the first request cycle) gives writeback 2 cycles after acceptance.
- A new instruction can be accepted in cycle M+1.
- Wb_valid is never high in two consecutive cycles for the same instruction.
- All outputs are registered; there is no combinational path from Mem_ack to Mem_req.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments on every REQ cycle without ack.
  - When it reaches TIMEOUT, the next cycle has Mem_req=0, Mem_err=1 for one cycle, the FSM in IDLE, and no writeback.
  - If Mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins: normal completion, no error.
- `MEM_TIMEOUT_EN` absent: REQ waits indefinitely, Mem_err is constant 0, and no counter logic is synthesized.

## Structure
- Shared package holds:
  - opcode constants: OP_ADD … OP_MOV, OP_CMP=4'b1011, OP_LDR=4'b1101, OP_STR=4'b1110
  - FSM state typedef (IDLE, REQ)
  - default TIMEOUT
- The ALU and decode use the same opcode constants.
- One sub-module, `mem_timeout_counter` (clear, enable, terminal-count output), instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- Reset mid-REQ: assert rst while Mem_req=1 → Mem_req=0 immediately, Ex_ready=1, and no Wb_valid after release even if Mem_ack then pulses.
- ADD result: Opcode=0000, Alu_out=0x0000_0007, Rd=3, Condition_met=1 → next cycle Wb_valid=1, Wb_data=7, Wb_rd=3. Three back-to-back ops give three consecutive writebacks.
- Load with 3-cycle wait:
  - Stimulus: Opcode=1101, Alu_out=0x0000_1006, Rd=5; Mem_ack with Mem_rdata=0xDEAD_BEEF in the 3rd REQ cycle.
  - Response: Mem_addr=0x0000_1004, Mem_we=0, Ex_ready=0 for 3 cycles, then Wb_valid with Wb_data=0xDEAD_BEEF, Wb_rd=5.
- Store: Opcode=1110, Alu_out=0x20, Store_data=0x55 → Mem_we=1, Mem_wdata=0x55, Mem_addr=0x20; no Wb_valid after ack.
- Squash and compare:
  - Load with Condition_met=0 → no Mem_req and no Wb_valid.
  - Opcode=1011 → no Wb_valid.
- Timeout (`MEM_TIMEOUT_EN`, TIMEOUT=4):
  - No ack → Mem_req high exactly 4 cycles, Mem_err pulses once, no writeback.
  - Ack on the 4th cycle → normal writeback and Mem_err=0.
